dr_reg_isz: RTL

Parametrised data register (DR) successor for the basic-computer datapath: WIDTH-bit register with load, clear, increment and decrement, registered zero and carry/borrow flags, and an optional saturating mode. It embeds the ISZ micro-sequence (fetch operand, increment, write back, skip-if-zero) as a small FSM with memory read/write handshakes, so the control unit issues a single start pulse instead of sequencing T-states itself. It sits between the common bus (Data) and the memory interface.

---
 rtl/dr_reg_isz_if.sv | 32 +++
 rtl/dr_reg_isz.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dr_reg_isz_if.sv
// Bus/control bundle for the ISZ-capable data register.
// master = control unit / memory side, slave = register.
interface dr_reg_isz_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] Data;
  logic             LD;
  logic             INR;
  logic             DEC;
  logic             CLRR;
  logic             ISZ;
  logic             MemValid;
  logic             WrAck;
  logic [WIDTH-1:0] Q;
  logic             Z;
  logic             CO;
  logic             WrReq;
  logic             Busy;
  logic             Skip;

  modport master (
    output Data, LD, INR, DEC, CLRR,
    output ISZ, MemValid, WrAck,
    input  Q, Z, CO, WrReq, Busy, Skip
  );

  modport slave (
    input  Data, LD, INR, DEC, CLRR,
    input  ISZ, MemValid, WrAck,
    output Q, Z, CO, WrReq, Busy, Skip
  );
endinterface

// File: rtl/dr_reg_isz.sv
// Data register with INR/DEC/LD/CLR, flags, optional
// saturation and an embedded ISZ fetch/incr/write-back FSM.
module dr_reg_isz #(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic                CLK,
  input  logic                CLR,
  dr_reg_isz_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE, FETCH, INCR, WRITE
  } state_t;

  state_t           r_st;
  logic [WIDTH-1:0] r_q;
  logic             r_z;
  logic             r_co;
  logic             r_wrreq;
  logic             r_busy;
  logic             r_skip;

  state_t           w_st;
  logic [WIDTH-1:0] w_q;
  logic             w_co;
  logic             w_wrreq;
  logic             w_skip;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;

  assign w_inc = {1'b0, r_q} + (WIDTH+1)'(1);
  assign w_dec = {1'b0, r_q} - (WIDTH+1)'(1);

  always_comb begin
    w_st    = r_st;
    w_q     = r_q;
    w_co    = r_co;
    w_wrreq = 1'b0;
    w_skip  = 1'b0;
    unique case (r_st)
      IDLE: begin
        if (bus.ISZ) begin
          w_st = FETCH;
        end else if (bus.CLRR) begin
          w_q  = '0;
          w_co = 1'b0;
        end else if (bus.LD) begin
          w_q  = bus.Data;
          w_co = 1'b0;
        end else if (bus.INR) begin
          if (SAT && (&r_q)) begin
            w_co = 1'b1;
          end else begin
            w_q  = w_inc[WIDTH-1:0];
            w_co = w_inc[WIDTH];
          end
        end else if (bus.DEC) begin
          if (SAT && (r_q == '0)) begin
            w_co = 1'b1;
          end else begin
            w_q  = w_dec[WIDTH-1:0];
            w_co = w_dec[WIDTH];
          end
        end
      end
      FETCH: begin
        if (bus.MemValid) begin
          w_q  = bus.Data;
          w_co = 1'b0;
          w_st = INCR;
        end
      end
      INCR: begin
        // ISZ always wraps so the zero skip can fire
        w_q     = w_inc[WIDTH-1:0];
        w_co    = w_inc[WIDTH];
        w_st    = WRITE;
        w_wrreq = 1'b1;
      end
      WRITE: begin
        w_wrreq = 1'b1;
        if (bus.WrAck) begin
          w_st    = IDLE;
          w_wrreq = 1'b0;
          w_skip  = (r_q == '0);
        end
      end
      default: w_st = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_st    <= IDLE;
      r_q     <= '0;
      r_z     <= 1'b1;
      r_co    <= 1'b0;
      r_wrreq <= 1'b0;
      r_busy  <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_st    <= w_st;
      r_q     <= w_q;
      r_z     <= (w_q == '0);
      r_co    <= w_co;
      r_wrreq <= w_wrreq;
      r_busy  <= (w_st != IDLE);
      r_skip  <= w_skip;
    end
  end

  assign bus.Q     = r_q;
  assign bus.Z     = r_z;
  assign bus.CO    = r_co;
  assign bus.WrReq = r_wrreq;
  assign bus.Busy  = r_busy;
  assign bus.Skip  = r_skip;

endmodule
